// File: rtl/dmem_if.sv
// Data-SRAM request/response bundle between the execute-stage requester and dmem_responder.
// ready_o/resp_*_o are responder outputs; the requester drives the req_* signals.
interface dmem_if;
   logic        req_en;
   logic [3:0]  req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        ready_o;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;

   // Handshake: a request is accepted at a rising edge where req_en & ready_o; the requester
   // holds req_* stable while ready_o=0, and resp_valid_o pulses once per accepted request, in order.
   modport master (
      output req_en, req_wen, req_addr, req_wdata,
      input  ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   modport slave (
      input  req_en, req_wen, req_addr, req_wdata,
      output ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-port word RAM responder for the core's data-SRAM port, with programmable response latency.
// Optional DMEM_ERR_CHK_EN rejects out-of-range addresses and illegal byte-enable masks.
module dmem_responder #(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 0
) (
   input  logic       clk,
   input  logic       rst,
   dmem_if.slave      bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ready;
   logic                accept;
   logic                req_err;
   logic                wr_en;
   logic [ADDR_W-1:0]   idx;
   logic [31:0]         rdata_q;
   logic [31:0]         mem [2**ADDR_W];

   assign idx    = bus.req_addr[ADDR_W+1:2];
   assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept = bus.req_en && ready;
   // A request that lands on the reset edge is discarded entirely, including its write.
   assign wr_en  = accept && !rst && !req_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (WAIT_CYC == 0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en && bus.req_wen[i]) begin
            mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
         end
      end
   end

   // Non-blocking read of mem on the write edge captures the pre-write word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (accept) begin
         rdata_q <= req_err ? 32'd0 : mem[idx];
      end
   end

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.req_addr[1:0];

`ifdef DMEM_ERR_CHK_EN
   function automatic logic wen_legal(input logic [3:0] w);
      case (w)
         4'b0000, 4'b0001, 4'b0010, 4'b0100,
         4'b1000, 4'b0011, 4'b1100, 4'b1111: wen_legal = 1'b1;
         default:                            wen_legal = 1'b0;
      endcase
   endfunction

   logic err_q;

   assign req_err = (|bus.req_addr[31:ADDR_W+2]) || !wen_legal(bus.req_wen);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= req_err;
      end
   end

   assign bus.resp_err_o = err_q && (state_q == S_DONE);
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

   assign req_err        = 1'b0;
   assign bus.resp_err_o = 1'b0;
`endif

   assign bus.ready_o      = ready;
   assign bus.resp_valid_o = (state_q == S_DONE);
   assign bus.resp_rdata_o = rdata_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYC = 0, 3, 2.
// Expected values are hand-computed; DMEM_ERR_CHK_EN selects the error-path expectations.
module tb_dmem_responder;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  en;
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  err;
  logic [31:0] rdata [3];
  logic [1:0]  dbg   [3];

  int n_total = 0;
  int n_bad   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_if bus ();
    assign bus.req_en    = en[g];
    assign bus.req_wen   = wen[g];
    assign bus.req_addr  = addr[g];
    assign bus.req_wdata = wdata[g];
    assign rdy[g]        = bus.ready_o;
    assign vld[g]        = bus.resp_valid_o;
    assign err[g]        = bus.resp_err_o;
    assign rdata[g]      = bus.resp_rdata_o;

    dmem_responder #(
      .ADDR_W  (10),
      .WAIT_CYC((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .bus      (bus),
      .dbg_state(dbg[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    en[k]    = e;
    wen[k]   = w;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  // Present one request (instance assumed ready), drop it after the accept edge,
  // and wait a bounded number of cycles for its response.
  task automatic txn(input int k, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, output int lat,
                     output logic [31:0] rd, output logic re);
    drive(k, 1'b1, w, a, d);
    step();
    drive(k, 1'b0, 4'h0, 32'h0, 32'h0);
    lat = 1;
    while (!vld[k] && lat < 10) begin
      step();
      lat++;
    end
    rd = rdata[k];
    re = err[k];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        re;
    logic        any_vld;

    rst = 3'b111;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    rst = 3'b000;

    // 1: reset then idle
    for (int c = 0; c < 10; c++) begin
      check("idle_ready", 32'(rdy[0]), 32'd1);
      check("idle_valid", 32'(vld[0]), 32'd0);
      check("idle_rdata", rdata[0], 32'h0);
      step();
    end
    check("idle_err",   32'(err[0]), 32'd0);
    check("idle_state", 32'(dbg[0]), 32'd0);
    check("idle_ready_w3", 32'(rdy[1]), 32'd1);
    check("idle_valid_w2", 32'(vld[2]), 32'd0);

    // 2: write then read back-to-back, WAIT_CYC=0
    drive(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
    step();
    check("b2b_wr_valid", 32'(vld[0]), 32'd1);
    check("b2b_wr_ready", 32'(rdy[0]), 32'd1);
    drive(0, 1'b1, 4'b0000, 32'h10, 32'h0);
    step();
    check("b2b_rd_valid", 32'(vld[0]), 32'd1);
    check("b2b_rd_data",  rdata[0], 32'hDEADBEEF);
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("b2b_after_valid", 32'(vld[0]), 32'd0);
    check("b2b_held_data",   rdata[0], 32'hDEADBEEF);

    // 3: byte and halfword lanes, plus read-before-write on the write response
    txn(0, 4'b1111, 32'h20, 32'h11223344, lat, rd, re);
    check("lane_lat", 32'(lat), 32'd1);
    txn(0, 4'b0010, 32'h20, 32'h55555555, lat, rd, re);
    check("lane_b1_old", rd, 32'h11223344);
    txn(0, 4'b1100, 32'h20, 32'hAAAAAAAA, lat, rd, re);
    check("lane_h1_old", rd, 32'h11225544);
    txn(0, 4'b0000, 32'h20, 32'h0, lat, rd, re);
    check("lane_final", rd, 32'hAAAA5544);

    // 4: WAIT_CYC=3 stall with request held
    step();
    txn(1, 4'b1111, 32'h4, 32'hCAFEF00D, lat, rd, re);
    check("w3_wr_lat", 32'(lat), 32'd4);
    step();
    drive(1, 1'b1, 4'b0000, 32'h4, 32'h0);
    check("w3_ready_t", 32'(rdy[1]), 32'd1);
    step();
    check("w3_state_wait", 32'(dbg[1]), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("w3_ready_t%0d", i), 32'(rdy[1]), 32'd0);
      check($sformatf("w3_valid_t%0d", i), 32'(vld[1]), 32'd0);
      step();
    end
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    check("w3_valid_t4", 32'(vld[1]), 32'd1);
    check("w3_rdata_t4", rdata[1], 32'hCAFEF00D);
    step();
    check("w3_valid_t5", 32'(vld[1]), 32'd0);
    check("w3_ready_t5", 32'(rdy[1]), 32'd1);

    // 5: WAIT_CYC=2 reset during WAIT after a write
    drive(2, 1'b1, 4'b1111, 32'h0, 32'h12345678);
    step();
    drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
    check("w2_ready_wait", 32'(rdy[2]), 32'd0);
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    check("w2_rst_valid", 32'(vld[2]), 32'd0);
    check("w2_rst_ready", 32'(rdy[2]), 32'd1);
    any_vld = 1'b0;
    for (int c = 0; c < 5; c++) begin
      any_vld |= vld[2];
      step();
    end
    check("w2_no_resp", 32'(any_vld), 32'd0);
    txn(2, 4'b0000, 32'h0, 32'h0, lat, rd, re);
    check("w2_rd_lat",  32'(lat), 32'd3);
    check("w2_rd_data", rd, 32'h12345678);

    // 6: out-of-range address and illegal byte mask
    step();
    txn(0, 4'b1111, 32'h0, 32'h0BADF00D, lat, rd, re);
    txn(0, 4'b1111, 32'h8000_0000, 32'h77777777, lat, rd, re);
    check("oor_lat", 32'(lat), 32'd1);
`ifdef DMEM_ERR_CHK_EN
    check("oor_err",   32'(re), 32'd1);
    check("oor_rdata", rd, 32'h0);
    txn(0, 4'b0000, 32'h0, 32'h0, lat, rd, re);
    check("oor_target", rd, 32'h0BADF00D);
    check("oor_rd_err", 32'(re), 32'd0);
    txn(0, 4'b0101, 32'h0, 32'h99999999, lat, rd, re);
    check("wen_err",   32'(re), 32'd1);
    check("wen_rdata", rd, 32'h0);
    txn(0, 4'b0000, 32'h0, 32'h0, lat, rd, re);
    check("wen_target", rd, 32'h0BADF00D);
`else
    check("oor_err",   32'(re), 32'd0);
    check("oor_rdata", rd, 32'h0BADF00D);
    txn(0, 4'b0000, 32'h0, 32'h0, lat, rd, re);
    check("oor_target", rd, 32'h77777777);
    txn(0, 4'b0101, 32'h0, 32'h99999999, lat, rd, re);
    check("wen_err",   32'(re), 32'd0);
    check("wen_rdata", rd, 32'h77777777);
    txn(0, 4'b0000, 32'h0, 32'h0, lat, rd, re);
    check("wen_target", rd, 32'h77997799);
`endif

    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
